ringbuf_fir: RTL and testbench
==============================

Name: ringbuf_fir

Overview:
- Read-side engine for the audio sample ring buffer.
- On each start request it walks the buffer history by offset and fetches a coefficient per tap.
- It multiply-accumulates the taps, then rounds and saturates the sum to one 24-bit output sample.
- After each completed sample it pops the ring buffer once. It sits between the ring buffer and the mixer/output stage.

Parameters:
- TAPS, 16, number of taps; power of two, 2..16; offset range 0..TAPS-1.
- DW, 24, sample width, signed two's complement.
- CW, 18, coefficient width, signed Q1.(CW-1).
- OW, 4, offset/coef address width; must equal the ring buffer offset width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- start_i  in  1  request one output sample; sampled only in IDLE.
- busy_o  out  1  high while a sample is being computed.
- rb_offset_o  out  OW  ring buffer read offset (tap index k).
- rb_data_i  in  DW  ring buffer read data; combinational from rb_offset_o.
- rb_pop_o  out  1  one-cycle pulse advancing the ring buffer read pointer.
- coef_addr_o  out  OW  coefficient address, equals rb_offset_o.
- coef_i  in  CW  coefficient; combinational from coef_addr_o.
- data_o  out  DW  filtered sample; held until next result.
- valid_o  out  1  one-cycle pulse, data_o new.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, k=0, acc=0, prod_v=0.
- Reset values: data_o=0, valid_o=0, rb_pop_o=0, busy_o=0, rb_offset_o=0.
- Reset overrides everything, including mid-computation. An aborted sample produces no valid_o and no rb_pop_o.
- States: IDLE, MAC, DRAIN, ROUND.
- IDLE:
  - start_i=1 -> MAC, with k<=0, acc<=0.
  - start_i=0 -> stay in IDLE.
- MAC:
  - rb_offset_o=coef_addr_o=k.
  - prod_r <= rb_data_i*coef_i, full DW+CW signed product; prod_v<=1.
  - k increments each cycle.
  - When k==TAPS-1 -> DRAIN; k wraps to 0.
- Accumulate: whenever prod_v=1, acc <= acc + sign-extended prod_r.
  - acc width DW+CW+log2(TAPS) (46 at defaults), so no overflow is possible.
- DRAIN: final product accumulates; prod_v<=0 -> ROUND.
- ROUND:
  - r = (acc + 2^(CW-2)) >>> (CW-1), arithmetic shift, round half up.
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - Register the result into data_o; set valid_o<=1 and rb_pop_o<=1 for exactly one cycle -> IDLE.
- busy_o = (state != IDLE).
- Timing, with start accepted at cycle 0:
  - MAC occupies cycles 1..TAPS.
  - DRAIN is cycle TAPS+1; ROUND is cycle TAPS+2.
  - valid_o and rb_pop_o are high in cycle TAPS+3.
  - busy_o is high in cycles 1..TAPS+2.
  - Minimum sample period is TAPS+3 cycles.
- start_i while busy_o=1 is ignored, not queued.
- start_i in the cycle valid_o=1 (state is IDLE) is accepted, giving back-to-back operation.
- rb_offset_o is 0 whenever not in MAC.
- The ring buffer must not be popped by anyone else during MAC; its contents are assumed stable for the whole sample.

Decomposition:
- Shared package ringbuf_fir_pkg:
  - state enum {IDLE, MAC, DRAIN, ROUND};
  - localparams ACCW = DW+CW+$clog2(TAPS), RND = 1<<(CW-2), SHIFT = CW-1.
- One sub-module, fir_round_sat: combinational round-half-up shift plus saturation, ACCW -> DW.
  - Unit-testable on its own; reusable by the mixer.

Test Plan (TAPS=16, ring buffer and coefficient ROM modelled in the bench):
- Reset: hold rst=0 for 3 cycles with start_i=1.
  - Expect busy_o=0, valid_o=0, rb_pop_o=0, data_o=0, rb_offset_o=0 throughout.
- Single tap:
  - Setup: coef[3]=0x10000 (0.5), all other coefs 0; data at offset 3 = 0x000200, all other data random.
  - Stimulus: start at cycle 0.
  - Expect rb_offset_o to step 0..15 over cycles 1..16; valid_o=1 and rb_pop_o=1 at cycle 19 only; data_o=0x000100.
- Saturation:
  - All coefs 0x10000, all data 0x100000 (sum 2^23) -> data_o=0x7FFFFF.
  - All coefs 0x1FFFF, all data 0x800000 -> data_o=0x800000.
- Rounding: coef[0]=1, all other coefs 0.
  - data[0]=0x010000 -> data_o=0x000001.
  - data[0]=0x00FFFF -> data_o=0x000000.
  - data[0]=0xFF0000 (-65536) -> data_o=0x000000.
- Handshake:
  - start at cycle 0, start again at cycle 5 (busy) -> ignored, exactly one valid_o, at cycle 19.
  - start at cycle 19 -> accepted; next valid_o at cycle 38; rb_pop_o count = 2.
- Reset mid-operation: start at cycle 0, rst=0 at cycle 8.
  - Expect busy_o=0 from cycle 9, no valid_o or rb_pop_o ever, data_o=0.
  - A new start after reset release completes normally at start+19.

Source files
------------

// File: rtl/ringbuf_fir_pkg.sv
// Shared types and default sizing for the ring buffer FIR read engine.
package ringbuf_fir_pkg;

    localparam int TAPS  = 16;
    localparam int DW    = 24;
    localparam int CW    = 18;
    localparam int OW    = 4;
    localparam int ACCW  = DW + CW + $clog2(TAPS);
    localparam int RND   = 1 << (CW - 2);
    localparam int SHIFT = CW - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        ROUND = 2'd3
    } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic shift from a Q(CW-1) accumulator to DW bits,
// followed by saturation to the signed DW-bit range.
module fir_round_sat #(
    parameter int ACCW = 46,
    parameter int DW   = 24,
    parameter int CW   = 18
) (
    input  logic signed [ACCW-1:0] acc_i,
    output logic signed [DW-1:0]   sample_o
);

    localparam int SH = CW - 1;
    localparam logic signed [ACCW:0] RND_V  = (ACCW+1)'(1) <<< (CW - 2);
    localparam logic signed [ACCW:0] SAT_HI = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW:0] SAT_LO = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACCW:0] sum;
    logic signed [ACCW:0] shr;

    // One guard bit keeps the rounding add from wrapping at the extremes.
    always_comb begin
        sum = $signed({acc_i[ACCW-1], acc_i}) + RND_V;
        shr = sum >>> SH;
        if (shr > SAT_HI)
            sample_o = SAT_HI[DW-1:0];
        else if (shr < SAT_LO)
            sample_o = SAT_LO[DW-1:0];
        else
            sample_o = shr[DW-1:0];
    end

endmodule

// File: rtl/ringbuf_fir.sv
// Ring buffer read-side FIR: walks TAPS history offsets, MACs against the
// coefficient ROM, rounds/saturates to one sample and pops the buffer once.
module ringbuf_fir
    import ringbuf_fir_pkg::*;
#(
    parameter int TAPS = 16,
    parameter int DW   = 24,
    parameter int CW   = 18,
    parameter int OW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic [OW-1:0] rb_offset_o,
    input  logic [DW-1:0] rb_data_i,
    output logic          rb_pop_o,
    output logic [OW-1:0] coef_addr_o,
    input  logic [CW-1:0] coef_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o
);

    localparam int PW = DW + CW;
    localparam int AW = DW + CW + $clog2(TAPS);
    localparam logic [OW-1:0] LAST = OW'(TAPS - 1);

    state_t               state, state_nxt;
    logic [OW-1:0]        k;
    logic signed [PW-1:0] prod_r;
    logic                 prod_v;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod_ext;
    logic signed [DW-1:0] rs;

    assign prod_ext = $signed({{(AW-PW){prod_r[PW-1]}}, prod_r});

    fir_round_sat #(
        .ACCW (AW),
        .DW   (DW),
        .CW   (CW)
    ) u_round_sat (
        .acc_i    (acc),
        .sample_o (rs)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= '0;
            acc      <= '0;
            prod_r   <= '0;
            prod_v   <= 1'b0;
            data_o   <= '0;
            valid_o  <= 1'b0;
            rb_pop_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            valid_o  <= 1'b0;
            rb_pop_o <= 1'b0;
            // The product pipeline lags one cycle, so the last tap lands in DRAIN.
            if (prod_v)
                acc <= acc + prod_ext;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    prod_r <= $signed(rb_data_i) * $signed(coef_i);
                    prod_v <= 1'b1;
                    k      <= (k == LAST) ? '0 : k + 1'b1;
                end
                DRAIN: begin
                    prod_v <= 1'b0;
                end
                ROUND: begin
                    data_o   <= rs;
                    valid_o  <= 1'b1;
                    rb_pop_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = MAC;
            MAC:     if (k == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o      = (state != IDLE);
    assign rb_offset_o = (state == MAC) ? k : '0;
    assign coef_addr_o = rb_offset_o;

endmodule

// File: tb/tb_ringbuf_fir.sv
// Bench for ringbuf_fir: table vectors, timing sequences and random vectors
// against an arithmetic reference of the filter.
module tb_ringbuf_fir;

    localparam int TAPS = 16;
    localparam int DW   = 24;
    localparam int CW   = 18;
    localparam int OW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          busy_o;
    logic [OW-1:0] rb_offset_o;
    logic [DW-1:0] rb_data_i;
    logic          rb_pop_o;
    logic [OW-1:0] coef_addr_o;
    logic [CW-1:0] coef_i;
    logic [DW-1:0] data_o;
    logic          valid_o;

    logic [DW-1:0] data_mem [TAPS];
    logic [CW-1:0] coef_mem [TAPS];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rb_data_i = data_mem[rb_offset_o];
    assign coef_i    = coef_mem[coef_addr_o];

    ringbuf_fir #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .rb_offset_o (rb_offset_o),
        .rb_data_i   (rb_data_i),
        .rb_pop_o    (rb_pop_o),
        .coef_addr_o (coef_addr_o),
        .coef_i      (coef_i),
        .data_o      (data_o),
        .valid_o     (valid_o)
    );

    typedef struct {
        string         name;
        logic [CW-1:0] coef_all;
        int            tap;
        logic [CW-1:0] coef_tap;
        bit            rand_data;
        logic [DW-1:0] data_all;
        logic [DW-1:0] data_tap;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact dot product, then round half up and clamp.
    function automatic logic [DW-1:0] model();
        longint s = 0;
        for (int i = 0; i < TAPS; i++)
            s += longint'($signed(data_mem[i])) * longint'($signed(coef_mem[i]));
        s = (s + (longint'(1) << (CW-2))) >>> (CW-1);
        if (s > (longint'(1) << (DW-1)) - 1) s = (longint'(1) << (DW-1)) - 1;
        if (s < -(longint'(1) << (DW-1)))    s = -(longint'(1) << (DW-1));
        return DW'(s);
    endfunction

    // Start in the current cycle (cycle 0), then check every cycle up to TAPS+4.
    task automatic run_sample(input string nm, input logic [DW-1:0] exp);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= TAPS + 4; c++) begin
            if (c <= TAPS)
                chk({nm, "_offset"}, 32'(rb_offset_o), 32'(c - 1));
            else
                chk({nm, "_offset_idle"}, 32'(rb_offset_o), 32'd0);
            chk({nm, "_busy"},  32'(busy_o),   32'(c <= TAPS + 2));
            chk({nm, "_valid"}, 32'(valid_o),  32'(c == TAPS + 3));
            chk({nm, "_pop"},   32'(rb_pop_o), 32'(c == TAPS + 3));
            if (c == TAPS + 3)
                chk({nm, "_data"}, 32'(data_o), 32'(exp));
            if (c < TAPS + 4) tick();
        end
    endtask

    initial begin
        int nvalid, npop, vcyc1, vcyc2;

        rst     = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            data_mem[i] = 24'($urandom);
            coef_mem[i] = '0;
        end

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_busy",   32'(busy_o),      32'd0);
            chk("rst_valid",  32'(valid_o),     32'd0);
            chk("rst_pop",    32'(rb_pop_o),    32'd0);
            chk("rst_data",   32'(data_o),      32'd0);
            chk("rst_offset", 32'(rb_offset_o), 32'd0);
        end
        rst     = 1'b1;
        start_i = 1'b0;
        tick();

        vecs[0] = '{"single_tap", 18'h00000, 3, 18'h10000, 1'b1, 24'h000000, 24'h000200, 24'h000100};
        vecs[1] = '{"sat_pos",    18'h10000, 0, 18'h10000, 1'b0, 24'h100000, 24'h100000, 24'h7FFFFF};
        vecs[2] = '{"sat_neg",    18'h1FFFF, 0, 18'h1FFFF, 1'b0, 24'h800000, 24'h800000, 24'h800000};
        vecs[3] = '{"rnd_up",     18'h00000, 0, 18'h00001, 1'b1, 24'h000000, 24'h010000, 24'h000001};
        vecs[4] = '{"rnd_below",  18'h00000, 0, 18'h00001, 1'b1, 24'h000000, 24'h00FFFF, 24'h000000};
        vecs[5] = '{"rnd_neg",    18'h00000, 0, 18'h00001, 1'b1, 24'h000000, 24'hFF0000, 24'h000000};

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_mem[i] = (i == vecs[v].tap) ? vecs[v].coef_tap : vecs[v].coef_all;
                if (i == vecs[v].tap)   data_mem[i] = vecs[v].data_tap;
                else if (vecs[v].rand_data) data_mem[i] = 24'($urandom);
                else                    data_mem[i] = vecs[v].data_all;
            end
            run_sample(vecs[v].name, vecs[v].exp);
        end

        // Busy start ignored, start during valid accepted back to back.
        for (int i = 0; i < TAPS; i++) begin
            data_mem[i] = 24'($urandom);
            coef_mem[i] = 18'($urandom);
        end
        nvalid = 0; npop = 0; vcyc1 = -1; vcyc2 = -1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (valid_o) begin
                nvalid++;
                if (vcyc1 < 0) vcyc1 = c; else if (vcyc2 < 0) vcyc2 = c;
                chk("hs_data", 32'(data_o), 32'(model()));
            end
            if (rb_pop_o) npop++;
            start_i = (c == 5) || (c == 19);
            tick();
            start_i = 1'b0;
        end
        chk("hs_valid_count", 32'(nvalid), 32'd2);
        chk("hs_pop_count",   32'(npop),   32'd2);
        chk("hs_valid_cyc1",  32'(vcyc1),  32'd19);
        chk("hs_valid_cyc2",  32'(vcyc2),  32'd38);

        // Reset during MAC aborts the sample without any output activity.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        nvalid = 0; npop = 0;
        for (int c = 9; c <= 30; c++) begin
            chk("mid_rst_busy", 32'(busy_o), 32'd0);
            chk("mid_rst_data", 32'(data_o), 32'd0);
            if (valid_o) nvalid++;
            if (rb_pop_o) npop++;
            tick();
        end
        chk("mid_rst_valid_count", 32'(nvalid), 32'd0);
        chk("mid_rst_pop_count",   32'(npop),   32'd0);
        run_sample("after_rst", model());

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < TAPS; i++) begin
                data_mem[i] = 24'($urandom);
                coef_mem[i] = (r < 10) ? 18'($urandom_range(0, 4095)) : 18'($urandom);
            end
            run_sample("random", model());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
